// File: rtl/change_dispenser.sv
// Change dispenser: greedy coin payout (25/10/5/1) against per-denomination hopper inventory.
// Optional coin_ready timeout enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
    parameter int unsigned CURRENCY_WIDTH = 7,
    parameter int unsigned INIT_COUNT     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      dispense_valid,
    input  logic [CURRENCY_WIDTH-1:0] currency_change,
    input  logic                      coin_ready,
    input  logic                      refill,
    input  logic [1:0]                refill_denom,
    input  logic [7:0]                refill_qty,
    output logic                      coin_valid,
    output logic [1:0]                coin_denom,
    output logic                      busy,
    output logic                      change_done,
    output logic                      change_short,
    output logic [CURRENCY_WIDTH-1:0] short_amount,
    output logic                      overrun
);

    localparam int unsigned VW = CURRENCY_WIDTH + 5;

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_e;

    state_e                    state_q, state_d;
    logic [CURRENCY_WIDTH-1:0] remaining_q, remaining_d;
    logic [CURRENCY_WIDTH-1:0] short_amount_q, short_amount_d;
    logic [1:0]                coin_denom_q, coin_denom_d;
    logic                      short_q, short_d;
    logic                      overrun_q;
    logic [7:0]                inv_q [4];
    logic [7:0]                inv_d [4];
    logic [9:0]                inv_sum;
    logic                      handshake;
    logic                      pick_found;
    logic [1:0]                pick;

    function automatic logic [VW-1:0] coin_value(input logic [1:0] d);
        case (d)
            2'd0:    return VW'(1);
            2'd1:    return VW'(5);
            2'd2:    return VW'(10);
            default: return VW'(25);
        endcase
    endfunction

    assign handshake = (state_q == ISSUE) && coin_ready;

`ifdef CHANGE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Zero outside ISSUE, so entering ISSUE always starts a fresh count
    assign tmo_d   = (state_q == ISSUE && !coin_ready) ? tmo_q + TW'(1) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Ascending scan: the last qualifying denomination is the largest
    always_comb begin
        pick_found = 1'b0;
        pick       = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (inv_q[i] != 8'd0 && coin_value(2'(i)) <= VW'(remaining_q)) begin
                pick_found = 1'b1;
                pick       = 2'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        short_amount_d = short_amount_q;
        coin_denom_d   = coin_denom_q;
        short_d        = short_q;
        case (state_q)
            IDLE: begin
                if (dispense_valid) begin
                    remaining_d    = currency_change;
                    short_amount_d = '0;
                    short_d        = 1'b0;
                    state_d        = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                end else if (pick_found) begin
                    coin_denom_d = pick;
                    state_d      = ISSUE;
                end else begin
                    short_amount_d = remaining_q;
                    short_d        = 1'b1;
                    state_d        = DONE;
                end
            end
            ISSUE: begin
                if (coin_ready) begin
                    remaining_d = remaining_q - CURRENCY_WIDTH'(coin_value(coin_denom_q));
                    state_d     = SELECT;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    short_amount_d = remaining_q;
                    short_d        = 1'b1;
                    state_d        = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Refill and payout may hit the same counter in one cycle: apply the net change
    always_comb begin
        inv_sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            inv_sum = {2'b00, inv_q[i]};
            if (refill && refill_denom == 2'(i))
                inv_sum = inv_sum + {2'b00, refill_qty};
            if (handshake && coin_denom_q == 2'(i))
                inv_sum = inv_sum - 10'd1;
            if (inv_sum[9])      inv_d[i] = '0;
            else if (inv_sum[8]) inv_d[i] = '1;
            else                 inv_d[i] = inv_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            short_amount_q <= '0;
            coin_denom_q   <= '0;
            short_q        <= 1'b0;
            overrun_q      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) inv_q[i] <= 8'(INIT_COUNT);
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            short_amount_q <= short_amount_d;
            coin_denom_q   <= coin_denom_d;
            short_q        <= short_d;
            overrun_q      <= dispense_valid && (state_q != IDLE);
            for (int unsigned i = 0; i < 4; i++) inv_q[i] <= inv_d[i];
        end
    end

    assign coin_valid   = (state_q == ISSUE);
    assign coin_denom   = coin_denom_q;
    assign busy         = (state_q != IDLE);
    assign change_done  = (state_q == DONE);
    assign change_short = (state_q == DONE) && short_q;
    assign short_amount = short_amount_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model predicts coins and completions.
// Defining CHANGE_TIMEOUT_EN adds a third instance with a short coin_ready timeout.
module tb_change_dispenser;

`ifdef CHANGE_TIMEOUT_EN
    localparam int NDUT = 3;
`else
    localparam int NDUT = 2;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       dv    [NDUT];
    logic [6:0] cc    [NDUT];
    logic       rdy   [NDUT];
    logic       rf    [NDUT];
    logic [1:0] rd    [NDUT];
    logic [7:0] rq    [NDUT];
    logic       cv    [NDUT];
    logic [1:0] cd    [NDUT];
    logic       bz    [NDUT];
    logic       cdn   [NDUT];
    logic       csh   [NDUT];
    logic [6:0] sam   [NDUT];
    logic       ovr   [NDUT];

    logic [1:0] exp_coin [NDUT][$];
    logic [7:0] exp_done [NDUT][$];
    int         inv_m    [NDUT][4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        change_dispenser #(
            .CURRENCY_WIDTH(7),
            .INIT_COUNT    ((g == 1) ? 1 : 8),
            .TIMEOUT_CYCLES((g == 2) ? 4 : 255)
        ) u_dut (
            .clk            (clk),
            .rstn           (rstn),
            .dispense_valid (dv[g]),
            .currency_change(cc[g]),
            .coin_ready     (rdy[g]),
            .refill         (rf[g]),
            .refill_denom   (rd[g]),
            .refill_qty     (rq[g]),
            .coin_valid     (cv[g]),
            .coin_denom     (cd[g]),
            .busy           (bz[g]),
            .change_done    (cdn[g]),
            .change_short   (csh[g]),
            .short_amount   (sam[g]),
            .overrun        (ovr[g])
        );

        always @(negedge clk) begin
            if (rstn) begin
                if (cv[g]) begin
                    if (exp_coin[g].size() == 0) begin
                        check($sformatf("coin_unexpected%0d", g), 1, 0);
                    end else if (rdy[g]) begin
                        check($sformatf("coin_denom%0d", g), cd[g], exp_coin[g].pop_front());
                    end else begin
                        check($sformatf("coin_stall_denom%0d", g), cd[g], exp_coin[g][0]);
                    end
                end
                if (cdn[g]) begin
                    if (exp_done[g].size() == 0) begin
                        check($sformatf("done_unexpected%0d", g), 1, 0);
                    end else begin
                        logic [7:0] e;
                        e = exp_done[g].pop_front();
                        check($sformatf("change_short%0d", g), csh[g], e[7]);
                        check($sformatf("short_amount%0d", g), sam[g], e[6:0]);
                    end
                end else if (csh[g]) begin
                    check($sformatf("short_without_done%0d", g), 1, 0);
                end
            end
        end
    end

    function automatic int denom_val(input int d);
        case (d)
            0:       return 1;
            1:       return 5;
            2:       return 10;
            default: return 25;
        endcase
    endfunction

    function automatic int unsigned dut_inv(input int g, input logic [1:0] d);
        int unsigned v;
        v = 0;
        if (g == 0)      v = 32'(g_dut[0].u_dut.inv_q[d]);
        else if (g == 1) v = 32'(g_dut[1].u_dut.inv_q[d]);
`ifdef CHANGE_TIMEOUT_EN
        else             v = 32'(g_dut[2].u_dut.inv_q[d]);
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NDUT; g++) begin
            for (int d = 0; d < 4; d++) inv_m[g][d] = (g == 1) ? 1 : 8;
            exp_coin[g].delete();
            exp_done[g].delete();
        end
    endtask

    task automatic pulse(input int g, input int amt);
        @(posedge clk); #1;
        dv[g] = 1'b1;
        cc[g] = 7'(amt);
        @(posedge clk); #1;
        dv[g] = 1'b0;
    endtask

    task automatic start_txn(input int g, input int amt);
        int rem;
        int pick;
        bit short_f;
        rem = amt;
        short_f = 1'b0;
        while (rem > 0) begin
            pick = -1;
            for (int d = 3; d >= 0; d--)
                if (pick < 0 && inv_m[g][d] > 0 && denom_val(d) <= rem) pick = d;
            if (pick < 0) begin
                short_f = 1'b1;
                break;
            end
            exp_coin[g].push_back(2'(pick));
            inv_m[g][pick]--;
            rem -= denom_val(pick);
        end
        exp_done[g].push_back({short_f, short_f ? 7'(rem) : 7'd0});
        pulse(g, amt);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while ((bz[g] || exp_done[g].size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check($sformatf("wait_idle%0d", g), 0, 1);
    endtask

    task automatic finish_txn(input int g);
        wait_idle(g);
        check($sformatf("coins_left%0d", g), exp_coin[g].size(), 0);
    endtask

    task automatic wait_coin(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (!cv[g] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check($sformatf("wait_coin%0d", g), 0, 1);
    endtask

    task automatic do_refill(input int g, input int denom, input int qty);
        @(posedge clk); #1;
        rf[g] = 1'b1;
        rd[g] = 2'(denom);
        rq[g] = 8'(qty);
        @(posedge clk); #1;
        rf[g] = 1'b0;
        inv_m[g][denom] = (inv_m[g][denom] + qty > 255) ? 255 : inv_m[g][denom] + qty;
    endtask

    task automatic check_inv(input int g, input string tag);
        for (int d = 0; d < 4; d++)
            check($sformatf("%s_inv%0d_%0d", tag, g, d), dut_inv(g, 2'(d)), inv_m[g][d]);
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            dv[g] = 1'b0; cc[g] = '0; rdy[g] = 1'b1;
            rf[g] = 1'b0; rd[g] = '0; rq[g] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("rst_coin_valid", cv[g], 0);
            check("rst_busy", bz[g], 0);
            check("rst_done", cdn[g], 0);
            check("rst_short", csh[g], 0);
            check("rst_short_amount", sam[g], 0);
            check("rst_overrun", ovr[g], 0);
            check("rst_coin_denom", cd[g], 0);
            check_inv(g, "rst");
        end
        @(posedge clk); #1;
        rstn = 1'b1;

        // 30 from full inventory: 25 then 5
        start_txn(0, 30);
        finish_txn(0);
        check("t30_inv25", dut_inv(0, 2'd3), 7);
        check("t30_inv5", dut_inv(0, 2'd1), 7);

        // zero change: done exactly two cycles after the request
        exp_done[0].push_back(8'd0);
        @(posedge clk); #1;
        dv[0] = 1'b1; cc[0] = 7'd0;
        @(posedge clk); #1;
        dv[0] = 1'b0;
        @(negedge clk);
        check("zero_busy_n1", bz[0], 1);
        check("zero_done_n1", cdn[0], 0);
        @(negedge clk);
        check("zero_done_n2", cdn[0], 1);
        @(negedge clk);
        check("zero_done_n3", cdn[0], 0);
        check("zero_idle_n3", bz[0], 0);

        // 10 with coin_ready held low three cycles
        rdy[0] = 1'b0;
        start_txn(0, 10);
        wait_coin(0);
        check("stall_c1_denom", cd[0], 2);
        @(negedge clk);
        check("stall_c2_valid", cv[0], 1);
        @(negedge clk);
        check("stall_c3_valid", cv[0], 1);
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        finish_txn(0);

        // request while busy is dropped
        start_txn(0, 30);
        dv[0] = 1'b1; cc[0] = 7'd40;
        @(posedge clk); #1;
        dv[0] = 1'b0;
        @(negedge clk);
        check("overrun_pulse", ovr[0], 1);
        @(negedge clk);
        check("overrun_clear", ovr[0], 0);
        finish_txn(0);
        check_inv(0, "after_overrun");

        // one coin of each denomination: 55 leaves 14 unpaid
        start_txn(1, 55);
        finish_txn(1);
        check_inv(1, "short55");

        // refill coinciding with a payout of the same denomination
        do_refill(1, 1, 3);
        rdy[1] = 1'b0;
        start_txn(1, 5);
        wait_coin(1);
        @(posedge clk); #1;
        rdy[1] = 1'b1; rf[1] = 1'b1; rd[1] = 2'd1; rq[1] = 8'd4;
        @(posedge clk); #1;
        rf[1] = 1'b0;
        inv_m[1][1] += 4;
        finish_txn(1);
        check("net_refill_inv5", dut_inv(1, 2'd1), 6);
        check_inv(1, "net_refill");

        // saturating refill, then mixed amounts against the model
        do_refill(0, 0, 255);
        check("sat_inv1", dut_inv(0, 2'd0), 255);
        for (int k = 0; k < 6; k++) begin
            start_txn(0, int'($urandom_range(0, 127)));
            finish_txn(0);
        end
        check_inv(0, "mixed");

        // reset in the middle of ISSUE aborts without a done pulse
        rdy[0] = 1'b0;
        start_txn(0, 10);
        wait_coin(0);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_coin_valid", cv[0], 0);
        check("abort_busy", bz[0], 0);
        model_reset();
        check_inv(0, "abort");
        @(posedge clk); #1;
        rstn = 1'b1;
        rdy[0] = 1'b1;
        start_txn(0, 6);
        finish_txn(0);

`ifdef CHANGE_TIMEOUT_EN
        begin
            int vcnt;
            int n;
            vcnt = 0;
            n = 0;
            rdy[2] = 1'b0;
            exp_coin[2].push_back(2'd1);
            exp_done[2].push_back({1'b1, 7'd5});
            pulse(2, 5);
            while (exp_done[2].size() != 0 && n < 40) begin
                @(negedge clk);
                if (cv[2]) vcnt++;
                n++;
            end
            if (n >= 40) check("tmo_wait", 0, 1);
            check("tmo_valid_cycles", vcnt, 4);
            check("tmo_no_handshake", exp_coin[2].size(), 1);
            exp_coin[2].delete();
            check_inv(2, "tmo");
            rdy[2] = 1'b1;
        end
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
